// File: rtl/cla_seq_pkg.sv
// Shared types for the multi-word carry-lookahead add/sub sequencer.
package cla_seq_pkg;

  // Sequencer states; encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_WORDS = 4;

endpackage

// File: rtl/cla_slice.sv
// Combinational WIDTH-bit carry-lookahead adder slice with carry in/out.
module cla_slice #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = i_add1 & i_add2;
  assign prop = i_add1 ^ i_add2;

  // Each carry is the group generate/propagate of bits [i:0] applied to the slice carry-in.
  always_comb begin
    logic grp_g;
    logic grp_p;
    grp_g    = 1'b0;
    grp_p    = 1'b1;
    carry    = '0;
    carry[0] = i_carry;
    for (int i = 0; i < WIDTH; i++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = 0; j <= i; j++) begin
        grp_g = gen[j] | (prop[j] & grp_g);
        grp_p = grp_p & prop[j];
      end
      carry[i+1] = grp_g | (grp_p & i_carry);
    end
  end

  assign o_result = prop ^ carry[WIDTH-1:0];
  assign o_carry  = carry[WIDTH];

endmodule

// File: rtl/cla_multiword_seq.sv
// Adds or subtracts two WORDS*WIDTH-bit operands one WIDTH-bit slice per clock, LSW first,
// through a single shared CLA slice with the inter-slice carry held in a register.
module cla_multiword_seq #(
  parameter int WIDTH = 24,
  parameter int WORDS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_sub,
  input  logic [WORDS*WIDTH-1:0] i_add1,
  input  logic [WORDS*WIDTH-1:0] i_add2,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [WORDS*WIDTH-1:0] o_result,
  output logic                   o_carry
);

  import cla_seq_pkg::*;

  localparam int TOTAL = WORDS * WIDTH;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [TOTAL-1:0] op_a;
  logic [TOTAL-1:0] op_b;

  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [WIDTH-1:0] slice_sum;
  logic             slice_co;

  assign slice_a = op_a[int'(idx)*WIDTH +: WIDTH];
  assign slice_b = op_b[int'(idx)*WIDTH +: WIDTH];

  cla_slice #(
    .WIDTH(WIDTH)
  ) u_slice (
    .i_add1  (slice_a),
    .i_add2  (slice_b),
    .i_carry (carry_reg),
    .o_result(slice_sum),
    .o_carry (slice_co)
  );

  // Sequencer FSM: accept in IDLE/DONE, one slice per clock in RUN, single done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      o_result  <= '0;
      o_carry   <= 1'b0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
      o_ready   <= 1'b1;
    end else begin
      o_done <= 1'b0;
      if (state == ST_RUN) begin
        o_result[int'(idx)*WIDTH +: WIDTH] <= slice_sum;
        carry_reg <= slice_co;
        if (idx == LAST_IDX) begin
          o_carry <= slice_co;
          o_done  <= 1'b1;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
          state   <= ST_DONE;
        end else begin
          idx <= idx + 1'b1;
        end
      end else if (i_start) begin
        op_a      <= i_add1;
        op_b      <= i_sub ? ~i_add2 : i_add2;
        carry_reg <= i_sub;
        idx       <= '0;
        o_busy    <= 1'b1;
        o_ready   <= 1'b0;
        state     <= ST_RUN;
      end else begin
        o_busy  <= 1'b0;
        o_ready <= 1'b1;
        state   <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Self-checking bench for cla_multiword_seq with WIDTH=24, WORDS=4.
module tb_cla_multiword_seq;

  localparam int W  = 24;
  localparam int N  = 4;
  localparam int TW = W * N;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic [TW-1:0] add1;
  logic [TW-1:0] add2;
  logic          ready;
  logic          busy;
  logic          done;
  logic [TW-1:0] result;
  logic          carry;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          sub;
    logic [TW-1:0] exp_r;
    logic          exp_c;
  } vec_t;

  vec_t vecs[13];

  cla_multiword_seq #(
    .WIDTH(W),
    .WORDS(N)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_sub   (sub),
    .i_add1  (add1),
    .i_add2  (add2),
    .o_ready (ready),
    .o_busy  (busy),
    .o_done  (done),
    .o_result(result),
    .o_carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from IDLE/DONE and waits (bounded) for its done pulse.
  task automatic applyStimulus(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic s,
                               output int cycles);
    add1  = a;
    add2  = b;
    sub   = s;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    add1  = ~a;
    add2  = ~b;
    sub   = ~s;
    cycles = 0;
    do begin
      stepCycle();
      cycles++;
    end while (!done && cycles < 20);
  endtask

  initial begin
    int cycles;
    int ndone;
    logic [TW-1:0] seen_r;
    logic [TW:0]   model;
    logic [TW-1:0] ra;
    logic [TW-1:0] rb;
    logic          rs;

    vecs[0]  = '{{TW{1'b1}}, 96'd1, 1'b0, 96'd0, 1'b1};
    vecs[1]  = '{96'd5, 96'd7, 1'b1, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0};
    vecs[2]  = '{96'd7, 96'd5, 1'b1, 96'd2, 1'b1};
    vecs[3]  = '{96'd0, 96'd0, 1'b0, 96'd0, 1'b0};
    vecs[4]  = '{96'h80000000_00000000_00000000, 96'h80000000_00000000_00000000, 1'b0, 96'd0, 1'b1};
    vecs[5]  = '{96'd1, 96'd2, 1'b0, 96'd3, 1'b0};
    vecs[6]  = '{96'hFFFFFF, 96'd1, 1'b0, 96'h1000000, 1'b0};
    vecs[7]  = '{96'd5, 96'd5, 1'b1, 96'd0, 1'b1};
    vecs[8]  = '{96'd0, 96'd1, 1'b1, {TW{1'b1}}, 1'b0};
    vecs[9]  = '{96'h123456_789ABC_DEF012_345678, 96'h111111_111111_111111_111111, 1'b0,
                 96'h234567_89ABCD_F00123_456789, 1'b0};
    vecs[10] = '{96'h1000000, 96'd1, 1'b1, 96'hFFFFFF, 1'b1};
    vecs[11] = '{96'h800000_000000_000000_000001, 96'h800000_000000_000000_000000, 1'b0, 96'd1, 1'b1};
    vecs[12] = '{96'd0, 96'd0, 1'b1, 96'd0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    add1  = '0;
    add2  = '0;
    repeat (3) stepCycle();
    checkOutput("reset ready", 128'(ready), 128'd1);
    checkOutput("reset busy", 128'(busy), 128'd0);
    checkOutput("reset done", 128'(done), 128'd0);
    checkOutput("reset result", 128'(result), 128'd0);
    checkOutput("reset carry", 128'(carry), 128'd0);
    rst_n = 1'b1;
    stepCycle();

    // Directed table
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sub, cycles);
      checkOutput($sformatf("vec%0d latency", i), 128'(cycles), 128'd4);
      checkOutput($sformatf("vec%0d result", i), 128'(result), 128'(vecs[i].exp_r));
      checkOutput($sformatf("vec%0d carry", i), 128'(carry), 128'(vecs[i].exp_c));
      checkOutput($sformatf("vec%0d ready", i), 128'(ready), 128'd1);
      checkOutput($sformatf("vec%0d busy", i), 128'(busy), 128'd0);
      stepCycle();
      checkOutput($sformatf("vec%0d done pulse", i), 128'(done), 128'd0);
    end

    // Start while busy is ignored
    add1 = 96'd1; add2 = 96'd2; sub = 1'b0; start = 1'b1;
    stepCycle();
    start = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("busy during run", 128'(busy), 128'd1);
    checkOutput("ready during run", 128'(ready), 128'd0);
    add1 = 96'd9; start = 1'b1;
    stepCycle();
    start = 1'b0;
    ndone = 0;
    seen_r = '0;
    for (int c = 0; c < 10; c++) begin
      stepCycle();
      if (done) begin
        ndone++;
        seen_r = result;
      end
    end
    checkOutput("busy ignore done count", 128'(ndone), 128'd1);
    checkOutput("busy ignore result", 128'(seen_r), 128'd3);

    // Reset in the middle of an operation
    applyStimulus(96'd7, 96'd5, 1'b1, cycles);
    checkOutput("pre-reset carry", 128'(carry), 128'd1);
    add1 = {TW{1'b1}}; add2 = 96'd1; sub = 1'b0; start = 1'b1;
    stepCycle();
    start = 1'b0;
    stepCycle();
    stepCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midreset ready", 128'(ready), 128'd1);
    checkOutput("midreset busy", 128'(busy), 128'd0);
    checkOutput("midreset done", 128'(done), 128'd0);
    checkOutput("midreset result", 128'(result), 128'd0);
    checkOutput("midreset carry", 128'(carry), 128'd0);
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      stepCycle();
      if (done) ndone++;
    end
    checkOutput("aborted op done count", 128'(ndone), 128'd0);
    applyStimulus(vecs[4].a, vecs[4].b, 1'b0, cycles);
    checkOutput("post-reset latency", 128'(cycles), 128'd4);
    checkOutput("post-reset result", 128'(result), 128'd0);
    checkOutput("post-reset carry", 128'(carry), 128'd1);
    stepCycle();
    stepCycle();

    // Back-to-back with start held high: accept in IDLE, then in each DONE cycle
    add1 = vecs[0].a; add2 = vecs[0].b; sub = vecs[0].sub; start = 1'b1;
    stepCycle();
    for (int k = 0; k < 4; k++) begin
      cycles = 0;
      do begin
        stepCycle();
        cycles++;
      end while (!done && cycles < 20);
      checkOutput($sformatf("b2b%0d spacing", k), 128'(cycles), (k == 0) ? 128'd4 : 128'(N + 1));
      checkOutput($sformatf("b2b%0d result", k), 128'(result), 128'(vecs[k].exp_r));
      checkOutput($sformatf("b2b%0d carry", k), 128'(carry), 128'(vecs[k].exp_c));
      if (k < 3) begin
        add1 = vecs[k+1].a; add2 = vecs[k+1].b; sub = vecs[k+1].sub;
      end else begin
        start = 1'b0;
      end
    end
    stepCycle();

    // Random operations against a {carry,result} = A +/- B model
    for (int r = 0; r < 300; r++) begin
      ra = {$urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom()};
      rs = 1'($urandom_range(0, 1));
      if (r % 25 == 0) rb = ra;
      if (rs) model = {1'b0, ra} + {1'b0, ~rb} + 97'd1;
      else    model = {1'b0, ra} + {1'b0, rb};
      repeat ($urandom_range(0, 3)) stepCycle();
      applyStimulus(ra, rb, rs, cycles);
      checkOutput($sformatf("rand%0d latency", r), 128'(cycles), 128'd4);
      checkOutput($sformatf("rand%0d result", r), 128'(result), 128'(model[TW-1:0]));
      checkOutput($sformatf("rand%0d carry", r), 128'(carry), 128'(model[TW]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
